// File: rtl/aes_g_function.sv
// AES-128 key-schedule g-function: SubWord(RotWord(word_in)) ^ rcon, registered output.
// Define AES_G_IN_REG_EN to add an input register stage (latency 2 instead of 1).
module aes_g_function (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] word_in,
  input  logic [31:0] rcon,
  output logic        out_valid,
  output logic [31:0] g_out
);

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b;
      8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b;
      8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d;
      8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf;
      8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26;
      8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1;
      8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3;
      8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2;
      8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a;
      8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3;
      8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed;
      8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39;
      8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb;
      8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f;
      8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f;
      8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21;
      8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec;
      8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d;
      8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc;
      8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14;
      8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a;
      8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62;
      8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d;
      8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea;
      8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e;
      8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f;
      8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66;
      8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9;
      8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11;
      8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9;
      8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d;
      8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f;
      8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  logic        stage_valid;
  logic [31:0] stage_word;
  logic [31:0] stage_rcon;

`ifdef AES_G_IN_REG_EN
  // Data only loads on valid so idle cycles do not disturb the captured operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_word  <= 32'h0;
      stage_rcon  <= 32'h0;
    end else begin
      stage_valid <= in_valid;
      if (in_valid) begin
        stage_word <= word_in;
        stage_rcon <= rcon;
      end
    end
  end
`else
  assign stage_valid = in_valid;
  assign stage_word  = word_in;
  assign stage_rcon  = rcon;
`endif

  logic [31:0] rot_word;
  logic [31:0] g_d;
  logic [31:0] g_q;
  logic        valid_q;

  assign rot_word = {stage_word[23:0], stage_word[31:24]};
  assign g_d = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                sbox(rot_word[15:8]), sbox(rot_word[7:0])} ^ stage_rcon;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      g_q     <= 32'h0;
    end else begin
      valid_q <= stage_valid;
      if (stage_valid) g_q <= g_d;
    end
  end

  assign out_valid = valid_q;
  assign g_out     = g_q;

endmodule

// File: tb/tb_aes_g_function.sv
// Self-checking bench for aes_g_function; the reference S-box is derived from GF(2^8)
// inversion plus the affine map, and a delay queue models the configured latency.
module tb_aes_g_function;

`ifdef AES_G_IN_REG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] word_in;
  logic [31:0] rcon;
  logic        out_valid;
  logic [31:0] g_out;

  aes_g_function dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .word_in  (word_in),
    .rcon     (rcon),
    .out_valid(out_valid),
    .g_out    (g_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  logic [7:0]  sbox_tab [256];
  logic        pend_v [$];
  logic [31:0] pend_g [$];
  logic        exp_v;
  logic [31:0] exp_g;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (b != 0 && gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_tab[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                    ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] g_model(input logic [31:0] w, input logic [31:0] r);
    logic [31:0] rw, res;
    rw = (w << 8) | (w >> 24);
    for (int i = 0; i < 4; i++) res[i*8 +: 8] = sbox_tab[rw[i*8 +: 8]];
    return res ^ r;
  endfunction

  task automatic model_flush();
    pend_v.delete();
    pend_g.delete();
    for (int i = 0; i < Lat - 1; i++) begin
      pend_v.push_back(1'b0);
      pend_g.push_back(32'h0);
    end
    exp_v = 1'b0;
    exp_g = 32'h0;
  endtask

  // One clock of stimulus; exp_v/exp_g then describe what the DUT should show.
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] r);
    logic [31:0] g_tmp;
    @(negedge clk);
    in_valid = v; word_in = w; rcon = r;
    pend_v.push_back(v);
    pend_g.push_back(g_model(w, r));
    @(posedge clk);
    #1;
    exp_v = pend_v.pop_front();
    g_tmp = pend_g.pop_front();
    if (exp_v) exp_g = g_tmp;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (out_valid !== 1'b0 || g_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: got v=%b g=%h want v=0 g=00000000", out_valid, g_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_flush();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, $urandom, $urandom);
      checks++;
      if (out_valid !== 1'b0 || g_out !== 32'h0) begin
        errors++;
        $display("FAIL reset_idle: got v=%b g=%h want v=0 g=00000000", out_valid, g_out);
      end
    end
  endtask

  task automatic test_vectors();
    logic [31:0] vw [5] = '{32'h09cf4f3c, 32'h00000000, 32'hffffffff, 32'h72696e67,
                            32'h2b7e1516};
    logic [31:0] vr [5] = '{32'h01000000, 32'h01000000, 32'h36000000, 32'h01000000,
                            32'hdeadbeef};
    logic [31:0] vg [5] = '{32'h8b84eb01, 32'h62636363, 32'h20161616, 32'hf89f8540,
                            32'h0};
    vg[4] = g_model(vw[4], vr[4]);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, vw[k], vr[k]);
      for (int i = 0; i < Lat - 1; i++) step(1'b0, 32'h0, 32'h0);
      checks++;
      if (out_valid !== 1'b1 || g_out !== vg[k]) begin
        errors++;
        $display("FAIL vector%0d: got v=%b g=%h want v=1 g=%h", k, out_valid, g_out, vg[k]);
      end
      step(1'b0, 32'h0, 32'h0);
      checks++;
      if (out_valid !== 1'b0 || g_out !== vg[k]) begin
        errors++;
        $display("FAIL vector%0d_pulse: got v=%b g=%h want v=0 g=%h", k, out_valid, g_out,
                 vg[k]);
      end
    end
  endtask

  task automatic test_streaming();
    logic [7:0] rc [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                            8'h1b, 8'h36};
    int         run;
    int         max_run;
    run = 0; max_run = 0;
    for (int i = 0; i < 10 + 1 + 3 + Lat; i++) begin
      if (i < 10)       step(1'b1, $urandom, {rc[i], 24'h0});
      else if (i == 10) step(1'b0, $urandom, $urandom);
      else if (i < 14)  step(1'b1, $urandom, {rc[i - 11], 24'h0});
      else              step(1'b0, $urandom, $urandom);
      checks++;
      if (out_valid !== exp_v || g_out !== exp_g) begin
        errors++;
        $display("FAIL stream[%0d]: got v=%b g=%h want v=%b g=%h", i, out_valid, g_out,
                 exp_v, exp_g);
      end
      if (out_valid === 1'b1) run++;
      else run = 0;
      if (run > max_run) max_run = run;
    end
    checks++;
    if (max_run != 10) begin
      errors++;
      $display("FAIL stream_run: got %0d consecutive valid want 10", max_run);
    end
  endtask

  task automatic test_sbox_sweep();
    logic [7:0]  b;
    logic [31:0] s4;
    for (int i = 0; i < 256 + Lat; i++) begin
      b = 8'(i);
      if (i < 256) step(1'b1, {b, b, b, b}, 32'h0);
      else         step(1'b0, 32'h0, 32'h0);
      checks++;
      if (out_valid !== exp_v || g_out !== exp_g) begin
        errors++;
        $display("FAIL sbox[%0d]: got v=%b g=%h want v=%b g=%h", i, out_valid, g_out,
                 exp_v, exp_g);
      end
      if (i >= Lat - 1 && i < 255 + Lat) begin
        b  = 8'(i - (Lat - 1));
        s4 = {4{sbox_tab[b]}};
        checks++;
        if (g_out !== s4) begin
          errors++;
          $display("FAIL sbox_byte[%02h]: got %h want %h", b, g_out, s4);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, $urandom);
      checks++;
      if (out_valid !== exp_v || g_out !== exp_g) begin
        errors++;
        $display("FAIL random[%0d]: got v=%b g=%h want v=%b g=%h", i, out_valid, g_out,
                 exp_v, exp_g);
      end
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b1, $urandom, 32'h01000000);
    step(1'b1, $urandom, 32'h02000000);
    for (int i = 0; i < Lat - 1; i++) step(1'b1, $urandom, 32'h04000000);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || g_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b g=%h want v=0 g=00000000", out_valid, g_out);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_flush();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, $urandom, $urandom);
      checks++;
      if (out_valid !== 1'b0 || g_out !== 32'h0) begin
        errors++;
        $display("FAIL reset_flush[%0d]: got v=%b g=%h want v=0 g=00000000", i, out_valid,
                 g_out);
      end
    end
    step(1'b1, 32'h09cf4f3c, 32'h01000000);
    for (int i = 0; i < Lat - 1; i++) step(1'b0, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || g_out !== 32'h8b84eb01) begin
      errors++;
      $display("FAIL reset_resume: got v=%b g=%h want v=1 g=8b84eb01", out_valid, g_out);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    word_in  = 32'h0;
    rcon     = 32'h0;
    build_sbox();
    #1 rst_n = 1'b0;
    test_reset();
    test_vectors();
    test_streaming();
    test_sbox_sweep();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
